up_datapath: RTL and testbench

- 8-bit accumulator datapath for the simple microprocessor, directly downstream of the control unit (uP_CU).
- Consumes the control unit's control word: IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, Halt.
- Returns the status signals the control unit decodes: IR[7:5], Aeq0, Apos.
- Holds IR, PC, accumulator A, and a 32x8 unified program/data RAM with a side-band loader port for the testbench and boot.

---
 rtl/up_pkg.sv | 28 ++
 rtl/up_ram.sv | 27 ++
 rtl/up_datapath.sv | 141 ++++++++++++++
 tb/tb_up_datapath.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/up_pkg.sv
// Shared definitions for the microprocessor datapath: widths, opcode
// field values decoded by the control unit, and accumulator source selects.
package up_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 5;

  // Opcode field IR[7:5]
  typedef enum logic [2:0] {
    LOAD  = 3'b000,
    STORE = 3'b001,
    ADD   = 3'b010,
    SUB   = 3'b011,
    INPUT = 3'b100,
    JZ    = 3'b101,
    JPOS  = 3'b110,
    HALT  = 3'b111
  } opcode_e;

  // Accumulator source select
  typedef enum logic [1:0] {
    ASEL_ALU  = 2'b00,
    ASEL_IN   = 2'b01,
    ASEL_MEM  = 2'b10,
    ASEL_ZERO = 2'b11
  } asel_e;

endpackage

// File: rtl/up_ram.sv
// Unified program/data RAM, 2**ADDR_W words of DATA_W bits.
// Ports: clk; we/waddr/wdata synchronous write; raddr/rdata combinational read.
// A read at an address being written in the same cycle returns the old word.
module up_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset so a loaded program survives RESET
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/up_datapath.sv
// Accumulator datapath of the simple microprocessor: IR, PC, accumulator A
// and a unified program/data RAM with a side-band loader port.
// Ports:
//   CLOCK, RESET (async, active-low)
//   control word from the control unit: IRload, JMPmux, PCload, Meminst,
//     MemWr, Aload, Sub, Asel[1:0], Halt
//   Input           external switch data
//   ProgWe/ProgAddr/ProgData  loader write port (wins over MemWr)
//   IR[2:0]         opcode field back to the control unit
//   Aeq0, Apos      accumulator status
//   Output          accumulator value
//   Halted          Halt delayed one cycle
//   Ovf             signed overflow of the last ALU load; only active when
//                   UP_DATAPATH_OVF_EN is defined, otherwise tied low
module up_datapath #(
  parameter int unsigned DATA_W = up_pkg::DATA_W,
  parameter int unsigned ADDR_W = up_pkg::ADDR_W
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              IRload,
  input  logic              JMPmux,
  input  logic              PCload,
  input  logic              Meminst,
  input  logic              MemWr,
  input  logic              Aload,
  input  logic              Sub,
  input  logic [1:0]        Asel,
  input  logic              Halt,
  input  logic [DATA_W-1:0] Input,
  input  logic              ProgWe,
  input  logic [ADDR_W-1:0] ProgAddr,
  input  logic [DATA_W-1:0] ProgData,
  output logic [2:0]        IR,
  output logic              Aeq0,
  output logic              Apos,
  output logic [DATA_W-1:0] Output,
  output logic              Halted,
  output logic              Ovf
);

  import up_pkg::*;

  logic [DATA_W-1:0] ir_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [DATA_W-1:0] a_reg;
  logic              halted_reg;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] mem_rd;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] a_next;
  logic [ADDR_W-1:0] pc_next;

  // Shared read/write address for instruction fetch and data access
  assign addr = Meminst ? ir_reg[ADDR_W-1:0] : pc_reg;

  // Loader takes priority over a datapath store in the same cycle
  assign ram_we    = ProgWe | MemWr;
  assign ram_waddr = ProgWe ? ProgAddr : addr;
  assign ram_wdata = ProgWe ? ProgData : a_reg;

  up_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (CLOCK),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (addr),
    .rdata (mem_rd)
  );

  // Add/subtract, carry and borrow discarded
  assign alu_res = Sub ? (a_reg - mem_rd) : (a_reg + mem_rd);

  // Accumulator source mux
  always_comb begin
    a_next = a_reg;
    case (Asel)
      ASEL_ALU:  a_next = alu_res;
      ASEL_IN:   a_next = Input;
      ASEL_MEM:  a_next = mem_rd;
      ASEL_ZERO: a_next = '0;
      default:   a_next = a_reg;
    endcase
  end

  // Jump target or sequential increment (wraps at the top of memory)
  assign pc_next = JMPmux ? ir_reg[ADDR_W-1:0] : (pc_reg + ADDR_W'(1));

  // Architectural registers
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      ir_reg     <= '0;
      pc_reg     <= '0;
      a_reg      <= '0;
      halted_reg <= 1'b0;
    end else begin
      if (IRload) ir_reg <= mem_rd;
      if (PCload) pc_reg <= pc_next;
      if (Aload)  a_reg  <= a_next;
      halted_reg <= Halt;
    end
  end

`ifdef UP_DATAPATH_OVF_EN
  logic ovf_reg;
  logic ovf_next;
  logic m_sign;

  // Subtraction adds ~M, so the effective operand sign is inverted
  always_comb begin
    m_sign   = Sub ? ~mem_rd[DATA_W-1] : mem_rd[DATA_W-1];
    ovf_next = (a_reg[DATA_W-1] == m_sign) && (alu_res[DATA_W-1] != a_reg[DATA_W-1]);
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      ovf_reg <= 1'b0;
    end else if (Aload && (Asel == ASEL_ALU)) begin
      ovf_reg <= ovf_next;
    end
  end

  assign Ovf = ovf_reg;
`else
  assign Ovf = 1'b0;
`endif

  assign IR     = ir_reg[DATA_W-1:DATA_W-3];
  assign Aeq0   = (a_reg == '0);
  assign Apos   = ~a_reg[DATA_W-1];
  assign Output = a_reg;
  assign Halted = halted_reg;

endmodule

// File: tb/tb_up_datapath.sv
// Randomised and directed bench for up_datapath with an arithmetic reference
// model; expected observations are queued by the driver and compared by an
// independent monitor on the falling clock edge.
module tb_up_datapath;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b0;
  logic       IRload = 1'b0, JMPmux = 1'b0, PCload = 1'b0, Meminst = 1'b0;
  logic       MemWr = 1'b0, Aload = 1'b0, Sub = 1'b0, Halt = 1'b0;
  logic [1:0] Asel = 2'b00;
  logic [7:0] Input = 8'h00;
  logic       ProgWe = 1'b0;
  logic [4:0] ProgAddr = 5'd0;
  logic [7:0] ProgData = 8'h00;
  logic [2:0] IR;
  logic       Aeq0, Apos, Halted, Ovf;
  logic [7:0] Output;

  up_datapath dut (
    .CLOCK(CLOCK), .RESET(RESET), .IRload(IRload), .JMPmux(JMPmux),
    .PCload(PCload), .Meminst(Meminst), .MemWr(MemWr), .Aload(Aload),
    .Sub(Sub), .Asel(Asel), .Halt(Halt), .Input(Input), .ProgWe(ProgWe),
    .ProgAddr(ProgAddr), .ProgData(ProgData), .IR(IR), .Aeq0(Aeq0),
    .Apos(Apos), .Output(Output), .Halted(Halted), .Ovf(Ovf)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic       irload, jmpmux, pcload, meminst, memwr, aload, sub, halt;
    logic [1:0] asel;
    logic [7:0] din;
    logic       pwe;
    logic [4:0] paddr;
    logic [7:0] pdata;
    logic       rst_pulse;
  } ctl_t;

  typedef struct {
    string      tag;
    logic [2:0] ir;
    logic       aeq0, apos;
    logic [7:0] out;
    logic       halted, ovf;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   passed = 0;

  // Reference model state
  int m_mem[32];
  int m_ir = 0, m_pc = 0, m_a = 0, m_halted = 0, m_ovf = 0;

  function automatic ctl_t idle();
    ctl_t c;
    c.irload = 0; c.jmpmux = 0; c.pcload = 0; c.meminst = 0; c.memwr = 0;
    c.aload = 0; c.sub = 0; c.halt = 0; c.asel = 2'd0; c.din = 8'h00;
    c.pwe = 0; c.paddr = 5'd0; c.pdata = 8'h00; c.rst_pulse = 0;
    return c;
  endfunction

  function automatic int to_signed8(int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  // Apply one control word for one rising edge and queue the expected result
  task automatic step(input string tag, input ctl_t c);
    int   addr, m, n_ir, n_pc, n_a, n_ovf, r;
    exp_t e;
    @(negedge CLOCK);
    IRload = c.irload; JMPmux = c.jmpmux; PCload = c.pcload; Meminst = c.meminst;
    MemWr = c.memwr; Aload = c.aload; Sub = c.sub; Asel = c.asel; Halt = c.halt;
    Input = c.din; ProgWe = c.pwe; ProgAddr = c.paddr; ProgData = c.pdata;
    if (c.rst_pulse) begin
      #1 RESET = 1'b0;
      m_ir = 0; m_pc = 0; m_a = 0; m_halted = 0; m_ovf = 0;
      #2 RESET = 1'b1;
    end
    addr  = c.meminst ? (m_ir % 32) : m_pc;
    m     = m_mem[addr];
    n_ir  = c.irload ? m : m_ir;
    n_pc  = c.pcload ? (c.jmpmux ? (m_ir % 32) : (m_pc + 1) % 32) : m_pc;
    n_a   = m_a;
    n_ovf = m_ovf;
    if (c.aload) begin
      case (c.asel)
        2'd0: n_a = c.sub ? (m_a - m + 256) % 256 : (m_a + m) % 256;
        2'd1: n_a = int'(c.din);
        2'd2: n_a = m;
        default: n_a = 0;
      endcase
      if (c.asel == 2'd0) begin
        r = c.sub ? to_signed8(m_a) - to_signed8(m) : to_signed8(m_a) + to_signed8(m);
        n_ovf = (r > 127 || r < -128) ? 1 : 0;
      end
    end
    if (c.pwe) m_mem[c.paddr] = int'(c.pdata);
    else if (c.memwr) m_mem[addr] = m_a;
    @(posedge CLOCK);
    #1;
    if (RESET == 1'b0) begin
      m_ir = 0; m_pc = 0; m_a = 0; m_halted = 0; m_ovf = 0;
    end else begin
      m_ir = n_ir; m_pc = n_pc; m_a = n_a; m_halted = c.halt ? 1 : 0; m_ovf = n_ovf;
    end
    e.tag    = tag;
    e.ir     = 3'(m_ir >> 5);
    e.aeq0   = (m_a == 0);
    e.apos   = (m_a < 128);
    e.out    = 8'(m_a);
    e.halted = (m_halted != 0);
`ifdef UP_DATAPATH_OVF_EN
    e.ovf    = (m_ovf != 0);
`else
    e.ovf    = 1'b0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic load(input int ad, input int d);
    ctl_t c = idle();
    c.pwe = 1; c.paddr = 5'(ad); c.pdata = 8'(d);
    step("load", c);
  endtask

  task automatic set_a(input int v);
    ctl_t c = idle();
    c.aload = 1; c.asel = 2'd1; c.din = 8'(v);
    step("set_a", c);
  endtask

  task automatic fetch();
    ctl_t c = idle();
    c.irload = 1;
    step("fetch", c);
  endtask

  task automatic alu(input logic sub);
    ctl_t c = idle();
    c.aload = 1; c.asel = 2'd0; c.meminst = 1; c.sub = sub;
    step(sub ? "alu_sub" : "alu_add", c);
  endtask

  task automatic pc_move(input logic jmp);
    ctl_t c = idle();
    c.pcload = 1; c.jmpmux = jmp;
    step(jmp ? "pc_jump" : "pc_inc", c);
  endtask

  task automatic probe(input logic mi);
    ctl_t c = idle();
    c.aload = 1; c.asel = 2'd2; c.meminst = mi;
    step(mi ? "probe_ir" : "probe_pc", c);
  endtask

  task automatic zero_a();
    ctl_t c = idle();
    c.aload = 1; c.asel = 2'd3;
    step("zero_a", c);
  endtask

  // Monitor: compare queued expectations with the DUT outputs
  initial begin : monitor
    exp_t       e;
    logic [14:0] got, want;
    forever begin
      @(negedge CLOCK);
      if (exp_q.size() > 0) begin
        e    = exp_q.pop_front();
        got  = {IR, Aeq0, Apos, Output, Halted, Ovf};
        want = {e.ir, e.aeq0, e.apos, e.out, e.halted, e.ovf};
        total++;
        if (got !== want)
          $display("FAIL %s @%0t: got ir=%0d aeq0=%0b apos=%0b out=%02h halted=%0b ovf=%0b, want ir=%0d aeq0=%0b apos=%0b out=%02h halted=%0b ovf=%0b",
                   e.tag, $time, IR, Aeq0, Apos, Output, Halted, Ovf,
                   e.ir, e.aeq0, e.apos, e.out, e.halted, e.ovf);
        else
          passed++;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin : driver
    ctl_t c;
    // Preload the program memory while the core is held in reset
    for (int i = 0; i < 32; i++) begin
      int v;
      v = (i * 29 + 17) % 256;
      if (i == 0) v = 8'h23;
      if (i == 3) v = 8'h42;
      if (i == 5) v = 8'h10;
      m_mem[i] = v;
      load(i, v);
    end
    RESET = 1'b1;

    // Fetch plus sequential PC, then jump to 31 and wrap to 0
    c = idle(); c.irload = 1; c.pcload = 1;
    step("ir_pc", c);
    load(1, 8'h3F);
    fetch();
    pc_move(1'b1);
    pc_move(1'b0);
    probe(1'b0);

    // ALU add/sub through IR-addressed operand RAM[5]=0x10
    load(0, 8'h45);
    fetch();
    set_a(8'h30); alu(1'b1);
    set_a(8'h30); alu(1'b0);
    set_a(8'h10); alu(1'b1);

    // Sign/zero status
    set_a(8'h80);
    zero_a();

    // Store and loader priority at address 9
    load(0, 8'h29);
    fetch();
    set_a(8'h77);
    c = idle(); c.memwr = 1; c.meminst = 1;
    step("store", c);
    zero_a(); probe(1'b1);
    set_a(8'h77);
    c = idle(); c.memwr = 1; c.meminst = 1; c.pwe = 1; c.paddr = 5'd9; c.pdata = 8'hEE;
    step("store_vs_loader", c);
    zero_a(); probe(1'b1);

    // Same-cycle store and load of one address reads the old word
    set_a(8'h11);
    c = idle(); c.memwr = 1; c.meminst = 1; c.aload = 1; c.asel = 2'd2;
    step("rw_same", c);
    probe(1'b1);

    // Halted follows Halt by one cycle
    c = idle(); c.halt = 1;
    step("halt", c);
    step("unhalt", idle());

    // Asynchronous reset mid-run with A=0x5A, PC=7; RAM survives
    load(0, 8'h07);
    fetch();
    pc_move(1'b1);
    set_a(8'h5A);
    c = idle(); c.rst_pulse = 1;
    step("async_reset", c);
    probe(1'b0);
    pc_move(1'b0); pc_move(1'b0); pc_move(1'b0);
    probe(1'b0);

    // Signed overflow corners with M=0x01 at RAM[10]
    load(3, 8'h0A);
    fetch();
    load(10, 8'h01);
    set_a(8'h7F); alu(1'b0);
    alu(1'b1);
    set_a(8'h01); alu(1'b0);

    // Random control words
    for (int n = 0; n < 400; n++) begin
      c.irload  = 1'($urandom);
      c.jmpmux  = 1'($urandom);
      c.pcload  = 1'($urandom);
      c.meminst = 1'($urandom);
      c.memwr   = ($urandom_range(0, 3) == 0);
      c.aload   = 1'($urandom);
      c.sub     = 1'($urandom);
      c.halt    = ($urandom_range(0, 7) == 0);
      c.asel    = 2'($urandom);
      c.din     = 8'($urandom);
      c.pwe     = ($urandom_range(0, 7) == 0);
      c.paddr   = 5'($urandom);
      c.pdata   = 8'($urandom);
      c.rst_pulse = ($urandom_range(0, 63) == 0);
      step("random", c);
    end

    step("drain", idle());
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge CLOCK);
    if (exp_q.size() > 0) begin
      total++;
      $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
    end
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
